fpu_arbiter: RTL

- Shares one Fixed_Point_Unit between two requesters, e.g. the execute stage (port 0) and a second client such as a CSR or vector helper (port 1).
- Arbitrates round-robin, captures the granted request, and drives the FPU operand and operation inputs stable until the FPU asserts ready.
- Pulses the FPU's active-high reset before every multicycle op (MUL/SQRT) to clear the FPU's sticky ready flags and internal state.
- Returns the result to the owner over a valid/ready response channel, with a timeout error path.

---
 rtl/fpu_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/fpu_arbiter.sv
// Two-port round-robin arbiter in front of a single fixed-point unit.
// Holds the granted op on the FPU until it is ready, with a one-cycle FPU clear before MUL/SQRT.
module fpu_arbiter #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [1:0]       req_op_0,
   input  logic [1:0]       req_op_1,
   input  logic [WIDTH-1:0] req_a_0,
   input  logic [WIDTH-1:0] req_a_1,
   input  logic [WIDTH-1:0] req_b_0,
   input  logic [WIDTH-1:0] req_b_1,
   output logic [1:0]       rsp_valid,
   input  logic [1:0]       rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_error,
   output logic [WIDTH-1:0] fpu_operand_1,
   output logic [WIDTH-1:0] fpu_operand_2,
   output logic [1:0]       fpu_operation,
   output logic             fpu_reset,
   input  logic [WIDTH-1:0] fpu_result,
   input  logic             fpu_ready
);

   localparam logic [1:0] FPU_ADD  = 2'd0;
   localparam logic [1:0] FPU_SUB  = 2'd1;
   localparam logic [1:0] FPU_MUL  = 2'd2;
   localparam logic [1:0] FPU_SQRT = 2'd3;

   localparam int unsigned   CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLEAR,
      S_WAIT,
      S_RESP
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             rr_ptr;
   logic             owner;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] result_q;
   logic             error_q;
   logic [CW-1:0]    cnt;

   logic             grant;
   logic             accept;
   logic [1:0]       sel_op;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic             timeout_hit;

   // A lone requester wins outright; rr_ptr only breaks ties.
   always_comb begin
      grant = rr_ptr;
      if (req_valid == 2'b01) begin
         grant = 1'b0;
      end else if (req_valid == 2'b10) begin
         grant = 1'b1;
      end
      sel_op = grant ? req_op_1 : req_op_0;
      sel_a  = grant ? req_a_1  : req_a_0;
      sel_b  = grant ? req_b_1  : req_b_0;
   end

   assign accept      = reset && (state == S_IDLE) && (req_valid != 2'b00);
   assign req_ready   = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
   assign timeout_hit = (cnt >= CNT_LAST);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (sel_op == FPU_MUL || sel_op == FPU_SQRT) begin
                  state_nxt = S_CLEAR;
               end else begin
                  state_nxt = S_WAIT;
               end
            end
         end
         S_CLEAR: state_nxt = S_WAIT;
         S_WAIT: begin
            if (fpu_ready || timeout_hit) begin
               state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready[owner]) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         rr_ptr   <= 1'b0;
         owner    <= 1'b0;
         op_q     <= FPU_ADD;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         error_q  <= 1'b0;
         cnt      <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  owner <= grant;
                  op_q  <= sel_op;
                  a_q   <= sel_a;
                  b_q   <= sel_b;
                  cnt   <= '0;
               end
            end
            S_WAIT: begin
               if (cnt != CNT_MAX) begin
                  cnt <= cnt + 1'b1;
               end
               // Ready takes priority over a timeout landing on the same edge.
               if (fpu_ready) begin
                  result_q <= fpu_result;
                  error_q  <= 1'b0;
               end else if (timeout_hit) begin
                  result_q <= '0;
                  error_q  <= 1'b1;
               end
            end
            S_RESP: begin
               if (rsp_ready[owner]) begin
                  rr_ptr <= ~owner;
                  cnt    <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      fpu_operation = FPU_ADD;
      fpu_operand_1 = '0;
      fpu_operand_2 = '0;
      if (state != S_IDLE) begin
         fpu_operation = op_q;
         fpu_operand_1 = a_q;
         fpu_operand_2 = b_q;
      end
   end

   assign fpu_reset  = ~reset | (state == S_CLEAR);
   assign rsp_valid  = (state == S_RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_result = result_q;
   assign rsp_error  = error_q;

endmodule
